// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Constants and types that the Hamming(21,16) encoder, decoder and receive
// deserializer share.
//   CW_BITS    : codeword length (21)
//   DATA_BITS  : payload length (16)
//   rx_state_t : receive framing state (IDLE, DATA, STOP, BREAK)
// ---------------------------------------------------------------------------
package hamming_pkg;

  localparam int CW_BITS   = 21;
  localparam int DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } rx_state_t;

endpackage

// File: rtl/hamming_rx_deser.sv
// ---------------------------------------------------------------------------
// hamming_rx_deser
// Serial-to-parallel front end of the Hamming(21,16) receive path. A frame is
// one start bit (0), 21 codeword bits and one stop bit (1). sin is sampled
// only on bit_en strobes. Good frames go into a one-entry valid/ready output
// register that drives the decoder input directly. Bad stop bits raise a
// one-cycle frame_err pulse and increment a saturating counter.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   bit_en    in   one-cycle strobe per bit period
//   sin       in   serial line, idles high
//   cw_out    out  [CW_BITS:1] codeword; bit 1 was received first
//   cw_valid  out  cw_out holds an unconsumed codeword
//   cw_ready  in   consumer accepts cw_out when cw_valid & cw_ready
//   frame_err out  one-cycle pulse: stop bit sampled as 0
//   overrun   out  sticky: a good frame was dropped because output was full
//   ovr_clr   in   clears overrun (a simultaneous new overrun wins)
//   err_cnt   out  [ERR_CNT_W-1:0] framing-error count, saturating
// ---------------------------------------------------------------------------
module hamming_rx_deser
  import hamming_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 sin,
  output logic [CW_BITS:1]     cw_out,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  rx_state_t              r_state;
  rx_state_t              w_state_next;
  logic [4:0]             r_bit_idx;
  logic [4:0]             w_bit_idx_next;
  logic [CW_BITS:1]       r_shreg;
  logic [CW_BITS:1]       r_cw;
  logic                   r_cw_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic w_stop_sample;
  logic w_good;
  logic w_bad;
  logic w_load;
  logic w_drop;

  assign w_stop_sample = (r_state == STOP) && bit_en;
  assign w_good        = w_stop_sample && sin;
  assign w_bad         = w_stop_sample && !sin;
  // A held word can be replaced only when it is consumed in this same cycle.
  assign w_load        = w_good && (!r_cw_valid || cw_ready);
  assign w_drop        = w_good && r_cw_valid && !cw_ready;

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_idx <= 5'd0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (!sin) begin
            w_state_next   = DATA;
            w_bit_idx_next = 5'd0;
          end
        end
        DATA: begin
          // Index stops at CW_BITS-1 and is rearmed to 0, so it never wraps.
          if (r_bit_idx == 5'(CW_BITS - 1)) begin
            w_state_next   = STOP;
            w_bit_idx_next = 5'd0;
          end else begin
            w_bit_idx_next = r_bit_idx + 5'd1;
          end
        end
        STOP: begin
          w_state_next = sin ? IDLE : BREAK;
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line is not
          // mistaken for a stream of start bits.
          if (sin) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // ---------------- Shift register ----------------
  // Samples enter at the top and shift down, so after 21 samples the first
  // received bit sits at position 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (bit_en && (r_state == DATA)) begin
      r_shreg <= {sin, r_shreg[CW_BITS:2]};
    end
  end

  // ---------------- Output stage and status ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw        <= '0;
      r_cw_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_cw       <= r_shreg;
        r_cw_valid <= 1'b1;
      end else if (r_cw_valid && cw_ready) begin
        r_cw_valid <= 1'b0;
      end

      r_frame_err <= w_bad;

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_bad && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign cw_out    = r_cw;
  assign cw_valid  = r_cw_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign err_cnt   = r_err_cnt;

endmodule
